// File: rtl/mem_ctrl_if.sv
// rtl/mem_ctrl_if.sv - requester (load/store and fetch) and byte-wide memory bus bundle for mem_ctrl
interface mem_ctrl_if;
    logic        lsb_en;
    logic        lsb_wr;
    logic [31:0] lsb_a;
    logic [2:0]  lsb_l;
    logic [31:0] lsb_w;
    logic        lsb_done;
    logic [31:0] lsb_r;
    logic        if_en;
    logic [31:0] if_a;
    logic        if_done;
    logic [31:0] if_data;
    logic [7:0]  mem_din;
    logic [7:0]  mem_dout;
    logic [31:0] mem_a;
    logic        mem_wr;
    logic        io_buffer_full;

    modport slave (
        input  lsb_en, lsb_wr, lsb_a, lsb_l, lsb_w, if_en, if_a, mem_din, io_buffer_full,
        output lsb_done, lsb_r, if_done, if_data, mem_dout, mem_a, mem_wr
    );

    modport master (
        output lsb_en, lsb_wr, lsb_a, lsb_l, lsb_w, if_en, if_a, mem_din, io_buffer_full,
        input  lsb_done, lsb_r, if_done, if_data, mem_dout, mem_a, mem_wr
    );
endinterface

// File: rtl/mem_ctrl.sv
// rtl/mem_ctrl.sv - byte-serial memory controller arbitrating data access and instruction fetch
// Optional IO_BUFFER_STALL_EN: hold IO stores in IDLE while io_buffer_full is high.
module mem_ctrl (
    input  logic        clk,
    input  logic        rst,
    input  logic        rdy,
    input  logic        rollback,
    mem_ctrl_if.slave   bus
);
    typedef enum logic [1:0] {IDLE, IF_RD, LS_RD, LS_WR} state_e;

    state_e      state_q, state_d;
    logic [2:0]  cnt_q, cnt_d;
    logic [2:0]  len_q, len_d;
    logic [31:0] mem_a_q, mem_a_d;
    logic [7:0]  mem_dout_q, mem_dout_d;
    logic        mem_wr_q, mem_wr_d;
    logic [31:0] w_q, w_d;
    logic [31:0] data_q, data_d;
    logic [31:0] lsb_r_q, lsb_r_d;
    logic [31:0] if_data_q, if_data_d;
    logic        lsb_done_q, lsb_done_d;
    logic        if_done_q, if_done_d;

    logic [2:0]  lsb_n;
    logic [2:0]  cnt_inc;
    logic        last;
    logic        ls_block;
    logic        accept_ls;
    logic        accept_if;
    logic [31:0] captured;

    always_comb begin
        case (bus.lsb_l)
            3'd1:    lsb_n = 3'd1;
            3'd2:    lsb_n = 3'd2;
            default: lsb_n = 3'd4;
        endcase
    end

`ifdef IO_BUFFER_STALL_EN
    assign ls_block = bus.lsb_en & bus.lsb_wr & (bus.lsb_a[17:16] == 2'b11) & bus.io_buffer_full;
`else
    // io_buffer_full has no effect in this build
    assign ls_block = bus.io_buffer_full & 1'b0;
`endif

    // a blocked store keeps lsb_en high, so a pending fetch cannot slip past it
    assign accept_ls = bus.lsb_en & ~ls_block;
    assign accept_if = bus.if_en & ~bus.lsb_en & ~rollback;
    assign cnt_inc   = cnt_q + 3'd1;
    assign last      = (cnt_inc == len_q);
    assign captured  = data_q | ({24'b0, bus.mem_din} << {cnt_q, 3'b000});

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= IDLE;
        end else if (rdy) begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (accept_ls) begin
                    state_d = bus.lsb_wr ? LS_WR : LS_RD;
                end else if (accept_if) begin
                    state_d = IF_RD;
                end
            end
            IF_RD: begin
                if (rollback || last) begin
                    state_d = IDLE;
                end
            end
            LS_RD, LS_WR: begin
                if (last) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        cnt_d      = cnt_q;
        len_d      = len_q;
        mem_a_d    = mem_a_q;
        mem_dout_d = mem_dout_q;
        mem_wr_d   = mem_wr_q;
        w_d        = w_q;
        data_d     = data_q;
        lsb_r_d    = lsb_r_q;
        if_data_d  = if_data_q;
        lsb_done_d = 1'b0;
        if_done_d  = 1'b0;
        case (state_q)
            IDLE: begin
                mem_a_d  = 32'd0;
                mem_wr_d = 1'b0;
                cnt_d    = 3'd0;
                data_d   = 32'd0;
                if (accept_ls) begin
                    mem_a_d = bus.lsb_a;
                    len_d   = lsb_n;
                    w_d     = bus.lsb_w;
                    if (bus.lsb_wr) begin
                        mem_wr_d   = 1'b1;
                        mem_dout_d = bus.lsb_w[7:0];
                    end
                end else if (accept_if) begin
                    mem_a_d = bus.if_a;
                    len_d   = 3'd4;
                end
            end
            IF_RD: begin
                if (rollback) begin
                    mem_a_d = 32'd0;
                    cnt_d   = 3'd0;
                end else if (last) begin
                    if_data_d = captured;
                    if_done_d = 1'b1;
                    mem_a_d   = 32'd0;
                    cnt_d     = 3'd0;
                end else begin
                    data_d  = captured;
                    mem_a_d = mem_a_q + 32'd1;
                    cnt_d   = cnt_inc;
                end
            end
            LS_RD: begin
                if (last) begin
                    lsb_r_d    = captured;
                    lsb_done_d = 1'b1;
                    mem_a_d    = 32'd0;
                    cnt_d      = 3'd0;
                end else begin
                    data_d  = captured;
                    mem_a_d = mem_a_q + 32'd1;
                    cnt_d   = cnt_inc;
                end
            end
            LS_WR: begin
                if (last) begin
                    lsb_done_d = 1'b1;
                    mem_wr_d   = 1'b0;
                    mem_a_d    = 32'd0;
                    mem_dout_d = 8'd0;
                    cnt_d      = 3'd0;
                end else begin
                    mem_a_d    = mem_a_q + 32'd1;
                    mem_dout_d = 8'(w_q >> {cnt_inc, 3'b000});
                    cnt_d      = cnt_inc;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt_q      <= 3'd0;
            len_q      <= 3'd0;
            mem_a_q    <= 32'd0;
            mem_dout_q <= 8'd0;
            mem_wr_q   <= 1'b0;
            w_q        <= 32'd0;
            data_q     <= 32'd0;
            lsb_r_q    <= 32'd0;
            if_data_q  <= 32'd0;
            lsb_done_q <= 1'b0;
            if_done_q  <= 1'b0;
        end else if (rdy) begin
            cnt_q      <= cnt_d;
            len_q      <= len_d;
            mem_a_q    <= mem_a_d;
            mem_dout_q <= mem_dout_d;
            mem_wr_q   <= mem_wr_d;
            w_q        <= w_d;
            data_q     <= data_d;
            lsb_r_q    <= lsb_r_d;
            if_data_q  <= if_data_d;
            lsb_done_q <= lsb_done_d;
            if_done_q  <= if_done_d;
        end else begin
            // a frozen pipeline must not stretch a completion pulse
            lsb_done_q <= 1'b0;
            if_done_q  <= 1'b0;
        end
    end

    assign bus.mem_a    = mem_a_q;
    assign bus.mem_dout = mem_dout_q;
    assign bus.mem_wr   = mem_wr_q & rdy;
    assign bus.lsb_done = lsb_done_q;
    assign bus.lsb_r    = lsb_r_q;
    assign bus.if_done  = if_done_q;
    assign bus.if_data  = if_data_q;
endmodule

// File: tb/tb_mem_ctrl.sv
// tb/tb_mem_ctrl.sv - self-checking bench for mem_ctrl against a byte-array memory model
module tb_mem_ctrl;
    logic clk = 1'b0;
    logic rst, rdy, rollback;
    always #5 clk = ~clk;

    mem_ctrl_if bus();
    mem_ctrl dut (.clk(clk), .rst(rst), .rdy(rdy), .rollback(rollback), .bus(bus.slave));

    logic [7:0] ram   [0:4095];
    logic [7:0] model [0:4095];
    int checks = 0;
    int errors = 0;
    int nwrites = 0;

    assign bus.mem_din = ram[bus.mem_a[11:0]];

    function automatic int nbytes(input logic [2:0] l);
        return (l == 3'd1) ? 1 : (l == 3'd2) ? 2 : 4;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // called at a negedge; applies any RAM write at the next posedge and returns at the following negedge
    task automatic tick();
        logic        wr;
        logic [31:0] a;
        logic [7:0]  d;
        wr = bus.mem_wr;
        a  = bus.mem_a;
        d  = bus.mem_dout;
        @(posedge clk);
        if (wr) begin
            ram[a[11:0]] = d;
            nwrites++;
        end
        @(negedge clk);
    endtask

    task automatic wait_done(input int kind, input logic [31:0] a, input int n,
                             input int stall_after, input int rb_after, input string tag);
        int          k;
        logic        d;
        logic [31:0] expv;
        k = 0;
        d = 1'b0;
        while (!d && k < 20) begin
            if (k == stall_after) begin
                rdy = 1'b0;
                tick();
                check({tag, "_stall_wr"}, {31'b0, bus.mem_wr}, 32'd0);
                tick();
                tick();
                rdy = 1'b1;
            end
            rollback = (k == rb_after);
            tick();
            k++;
            rollback = 1'b0;
            d = (kind == 0) ? bus.if_done : bus.lsb_done;
        end
        check({tag, "_latency"}, k, n);
        expv = 32'd0;
        for (int i = 0; i < n; i++) expv |= 32'(model[12'(a + 32'(i))]) << (8 * i);
        if (kind == 0) check({tag, "_if_data"}, bus.if_data, expv);
        if (kind == 1) check({tag, "_lsb_r"}, bus.lsb_r, expv);
        tick();
        check({tag, "_pulse_end"}, {31'b0, (kind == 0) ? bus.if_done : bus.lsb_done}, 32'd0);
    endtask

    // kind: 0 fetch, 1 load, 2 store
    task automatic xfer(input int kind, input logic [31:0] a, input logic [2:0] l, input logic [31:0] w,
                        input int stall_after, input int rb_after, input string tag);
        int n, w0;
        n  = (kind == 0) ? 4 : nbytes(l);
        w0 = nwrites;
        if (kind == 0) begin
            bus.if_en = 1'b1;
            bus.if_a  = a;
        end else begin
            bus.lsb_en = 1'b1;
            bus.lsb_wr = (kind == 2);
            bus.lsb_a  = a;
            bus.lsb_l  = l;
            bus.lsb_w  = w;
        end
        tick();
        bus.if_en  = 1'b0;
        bus.lsb_en = 1'b0;
        if (kind == 2)
            for (int i = 0; i < n; i++) model[12'(a + 32'(i))] = w[8*i +: 8];
        wait_done(kind, a, n, stall_after, rb_after, tag);
        check({tag, "_writes"}, nwrites - w0, (kind == 2) ? n : 0);
        if (kind == 2)
            for (int i = 0; i <= n; i++)
                check({tag, "_ram"}, 32'(ram[12'(a + 32'(i))]), 32'(model[12'(a + 32'(i))]));
        check({tag, "_idle_a"}, bus.mem_a, 32'd0);
        check({tag, "_idle_wr"}, {31'b0, bus.mem_wr}, 32'd0);
    endtask

    initial begin
        logic [7:0] v;
        int kind;
        int w0;
        rst = 1'b0; rdy = 1'b1; rollback = 1'b0;
        bus.lsb_en = 1'b0; bus.lsb_wr = 1'b0; bus.lsb_a = 32'd0; bus.lsb_l = 3'd0; bus.lsb_w = 32'd0;
        bus.if_en = 1'b0; bus.if_a = 32'd0; bus.io_buffer_full = 1'b0;
        for (int i = 0; i < 4096; i++) begin
            v = 8'($urandom);
            ram[i] = v;
            model[i] = v;
        end
        ram[12'h100] = 8'h11; ram[12'h101] = 8'h22; ram[12'h102] = 8'h33; ram[12'h103] = 8'h44;
        model[12'h100] = 8'h11; model[12'h101] = 8'h22; model[12'h102] = 8'h33; model[12'h103] = 8'h44;
        @(negedge clk);
        tick();
        tick();
        check("rst_mem_a", bus.mem_a, 32'd0);
        check("rst_mem_wr", {31'b0, bus.mem_wr}, 32'd0);
        check("rst_mem_dout", {24'b0, bus.mem_dout}, 32'd0);
        check("rst_done", {30'b0, bus.lsb_done, bus.if_done}, 32'd0);
        check("rst_lsb_r", bus.lsb_r, 32'd0);
        check("rst_if_data", bus.if_data, 32'd0);
        rst = 1'b1;

        xfer(0, 32'h100, 3'd0, 32'd0, -1, -1, "fetch100");
        check("fetch100_value", bus.if_data, 32'h44332211);

        xfer(2, 32'h200, 3'd2, 32'hAABBCCDD, -1, -1, "store200");
        check("store200_b0", 32'(ram[12'h200]), 32'hDD);
        check("store200_b1", 32'(ram[12'h201]), 32'hCC);

        bus.lsb_en = 1'b1; bus.lsb_wr = 1'b0; bus.lsb_a = 32'h100; bus.lsb_l = 3'd4;
        bus.if_en = 1'b1; bus.if_a = 32'h104;
        tick();
        bus.lsb_en = 1'b0;
        check("prio_ls_addr", bus.mem_a, 32'h100);
        wait_done(1, 32'h100, 4, -1, -1, "prio_ls");
        bus.if_en = 1'b0;
        check("prio_if_accept", bus.mem_a, 32'h104);
        wait_done(0, 32'h104, 4, -1, -1, "prio_if");

        bus.if_en = 1'b1; bus.if_a = 32'h100;
        tick();
        bus.if_en = 1'b0;
        tick();
        tick();
        rollback = 1'b1;
        tick();
        rollback = 1'b0;
        check("rb_fetch_idle", bus.mem_a, 32'd0);
        for (int i = 0; i < 5; i++) begin
            check("rb_fetch_no_done", {31'b0, bus.if_done}, 32'd0);
            tick();
        end
        xfer(1, 32'h100, 3'd4, 32'd0, -1, 1, "rb_load");
        check("rb_load_value", bus.lsb_r, 32'h44332211);

        bus.if_en = 1'b1; bus.if_a = 32'h300; rollback = 1'b1;
        tick();
        rollback = 1'b0;
        check("rb_idle_block", bus.mem_a, 32'd0);
        tick();
        bus.if_en = 1'b0;
        check("rb_idle_accept", bus.mem_a, 32'h300);
        wait_done(0, 32'h300, 4, -1, -1, "rb_idle_fetch");

        xfer(1, 32'h100, 3'd4, 32'd0, 1, -1, "stall_load");
        check("stall_load_value", bus.lsb_r, 32'h44332211);

        xfer(0, 32'hFFFF_FFFE, 3'd0, 32'd0, -1, -1, "wrap_fetch");

        bus.if_en = 1'b1; bus.if_a = 32'h100;
        tick();
        bus.if_en = 1'b0;
        tick();
        tick();
        rst = 1'b0; rdy = 1'b0; rollback = 1'b1;
        tick();
        rst = 1'b1; rdy = 1'b1; rollback = 1'b0;
        check("midrst_mem_a", bus.mem_a, 32'd0);
        check("midrst_if_data", bus.if_data, 32'd0);
        check("midrst_lsb_r", bus.lsb_r, 32'd0);
        for (int i = 0; i < 5; i++) begin
            check("midrst_no_done", {31'b0, bus.if_done}, 32'd0);
            tick();
        end

`ifdef IO_BUFFER_STALL_EN
        w0 = nwrites;
        bus.io_buffer_full = 1'b1;
        bus.lsb_en = 1'b1; bus.lsb_wr = 1'b1; bus.lsb_a = 32'h30000; bus.lsb_l = 3'd1; bus.lsb_w = 32'h5A;
        bus.if_en = 1'b1; bus.if_a = 32'h100;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("io_stall_wr", {31'b0, bus.mem_wr}, 32'd0);
            check("io_stall_idle", bus.mem_a, 32'd0);
        end
        bus.io_buffer_full = 1'b0;
        tick();
        bus.lsb_en = 1'b0;
        bus.if_en = 1'b0;
        model[12'h000] = 8'h5A;
        wait_done(2, 32'h30000, 1, -1, -1, "io_store");
        check("io_store_writes", nwrites - w0, 32'd1);
        check("io_store_ram", 32'(ram[12'h000]), 32'h5A);
`else
        w0 = nwrites;
        bus.io_buffer_full = 1'b1;
        xfer(2, 32'h30000, 3'd1, 32'h5A, -1, -1, "io_store");
        check("io_store_total", nwrites - w0, 32'd1);
        bus.io_buffer_full = 1'b0;
`endif

        for (int it = 0; it < 24; it++) begin
            kind = int'($urandom_range(0, 2));
            xfer(kind, 32'($urandom_range(0, 4095)), 3'($urandom), $urandom,
                 int'($urandom_range(0, 6)), int'($urandom_range(0, 6)) + ((kind == 0) ? 10 : 0), "rand");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
